// File: rtl/pipe_reg_chain.sv
// Chain of STAGES pipeline registers, each with its own stall and bubble control,
// plus per-stage valid tracking, a sticky stall/bubble conflict flag and saturating counters.
module pipe_reg_chain #(
  parameter int               WIDTH       = 64,
  parameter int               STAGES      = 4,
  parameter logic [WIDTH-1:0] BUBBLE_VAL  = '0,
  parameter int               AUTO_BUBBLE = 1,
  parameter int               CNT_W       = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_valid,
  input  logic [STAGES-1:0]         stall,
  input  logic [STAGES-1:0]         bubble,
  input  logic                      clear_cnt,
  output logic [STAGES*WIDTH-1:0]   stage_data,
  output logic [STAGES-1:0]         stage_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          bubble_cnt,
  output logic                      conflict
);

  logic [WIDTH-1:0]  data_q     [STAGES];
  logic [WIDTH-1:0]  prev_data  [STAGES];
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] prev_valid;
  logic [STAGES-1:0] eb;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  bubble_cnt_q;
  logic              conflict_q;

  // A stage whose feeder is stalled gets a bubble, so held data is never duplicated downstream.
  always_comb begin
    eb = bubble;
    if (AUTO_BUBBLE != 0) begin
      for (int k = 1; k < STAGES; k++) begin
        eb[k] = bubble[k] | (stall[k-1] & ~stall[k]);
      end
    end
  end

  always_comb begin
    prev_data[0]  = in_data;
    prev_valid[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      prev_data[k]  = data_q[k-1];
      prev_valid[k] = valid_q[k-1];
    end
  end

  // Priority per stage: reset, stall (hold), effective bubble, load from predecessor.
  always_ff @(posedge clock) begin
    for (int k = 0; k < STAGES; k++) begin
      if (reset) begin
        data_q[k]  <= BUBBLE_VAL;
        valid_q[k] <= 1'b0;
      end else if (stall[k]) begin
        data_q[k]  <= data_q[k];
        valid_q[k] <= valid_q[k];
      end else if (eb[k]) begin
        data_q[k]  <= BUBBLE_VAL;
        valid_q[k] <= 1'b0;
      end else begin
        data_q[k]  <= prev_data[k];
        valid_q[k] <= prev_valid[k];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      conflict_q   <= 1'b0;
    end else begin
      if (clear_cnt) begin
        stall_cnt_q  <= '0;
        bubble_cnt_q <= '0;
      end else begin
        if (stall[0] && (stall_cnt_q != '1)) begin
          stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
        if ((|(eb & ~stall)) && (bubble_cnt_q != '1)) begin
          bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
        end
      end
      if (|(stall & bubble)) begin
        conflict_q <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_out
    assign stage_data[g*WIDTH +: WIDTH] = data_q[g];
  end

  assign stage_valid = valid_q;
  assign out_data    = data_q[STAGES-1];
  assign out_valid   = valid_q[STAGES-1];
  assign stall_cnt   = stall_cnt_q;
  assign bubble_cnt  = bubble_cnt_q;
  assign conflict    = conflict_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain: three instances share one stimulus stream
// (auto bubble, no auto bubble, 3-bit counters) and are checked against hand-computed values.
module tb_pipe_reg_chain;

  localparam int W = 8;
  localparam int S = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic [S-1:0] stall;
  logic [S-1:0] bubble;
  logic         clear_cnt;

  logic [S*W-1:0] a_sd, b_sd, c_sd;
  logic [S-1:0]   a_sv, b_sv, c_sv;
  logic [W-1:0]   a_od, b_od, c_od;
  logic           a_ov, b_ov, c_ov;
  logic [15:0]    a_sc, a_bc, b_sc, b_bc;
  logic [2:0]     c_sc, c_bc;
  logic           a_cf, b_cf, c_cf;

  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  pipe_reg_chain #(.WIDTH(W), .STAGES(S), .BUBBLE_VAL(8'hF0), .AUTO_BUBBLE(1), .CNT_W(16)) u_a (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid), .stall(stall),
    .bubble(bubble), .clear_cnt(clear_cnt), .stage_data(a_sd), .stage_valid(a_sv),
    .out_data(a_od), .out_valid(a_ov), .stall_cnt(a_sc), .bubble_cnt(a_bc), .conflict(a_cf));

  pipe_reg_chain #(.WIDTH(W), .STAGES(S), .BUBBLE_VAL(8'hF0), .AUTO_BUBBLE(0), .CNT_W(16)) u_b (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid), .stall(stall),
    .bubble(bubble), .clear_cnt(clear_cnt), .stage_data(b_sd), .stage_valid(b_sv),
    .out_data(b_od), .out_valid(b_ov), .stall_cnt(b_sc), .bubble_cnt(b_bc), .conflict(b_cf));

  pipe_reg_chain #(.WIDTH(W), .STAGES(S), .BUBBLE_VAL(8'h00), .AUTO_BUBBLE(1), .CNT_W(3)) u_c (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid), .stall(stall),
    .bubble(bubble), .clear_cnt(clear_cnt), .stage_data(c_sd), .stage_valid(c_sv),
    .out_data(c_od), .out_valid(c_ov), .stall_cnt(c_sc), .bubble_cnt(c_bc), .conflict(c_cf));

  // clock / reset
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // driver
  task automatic drive(input logic [W-1:0] d, input logic v);
    in_data  = d;
    in_valid = v;
    step();
  endtask

  // checking
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] a_stage(input int k);
    return a_sd[k*W +: W];
  endfunction

  function automatic logic [W-1:0] b_stage(input int k);
    return b_sd[k*W +: W];
  endfunction

  initial begin
    reset = 1'b1; in_data = '0; in_valid = 1'b0;
    stall = '0; bubble = '0; clear_cnt = 1'b0;

    // reset state
    do_reset();
    check("rst_sd_a", a_sd, 32'hF0F0_F0F0);
    check("rst_sd_c", c_sd, 32'h0000_0000);
    check("rst_sv", a_sv, 4'b0000);
    check("rst_cnt", {a_sc, a_bc}, 32'h0);
    check("rst_cf", a_cf, 1'b0);

    // latency of STAGES cycles, one per cycle
    drive(8'h11, 1'b1);
    drive(8'h22, 1'b1);
    drive(8'h33, 1'b1);
    check("lat_ov_c3", a_ov, 1'b0);
    drive(8'h00, 1'b0);
    check("lat_c4", {a_ov, a_od}, {1'b1, 8'h11});
    drive(8'h00, 1'b0);
    check("lat_c5", {a_ov, a_od}, {1'b1, 8'h22});
    drive(8'h00, 1'b0);
    check("lat_c6", {a_ov, a_od}, {1'b1, 8'h33});
    drive(8'h00, 1'b0);
    check("lat_c7_ov", a_ov, 1'b0);
    check("lat_no_bub", a_bc, 16'd0);

    // stall 4'b0011 for two cycles in a streaming pipeline
    do_reset();
    for (int i = 0; i < 4; i++) drive(8'hA0 + W'(i), 1'b1);
    check("strm_first", {a_ov, a_od}, {1'b1, 8'hA0});
    stall = 4'b0011;
    drive(8'hA4, 1'b1);
    check("stl1_s0", a_stage(0), 8'hA3);
    check("stl1_s1", a_stage(1), 8'hA2);
    check("stl1_s2_a", {a_sv[2], a_stage(2)}, {1'b0, 8'hF0});
    check("stl1_s2_b", {b_sv[2], b_stage(2)}, {1'b1, 8'hA2});
    check("stl1_s3", {a_ov, a_od}, {1'b1, 8'hA1});
    drive(8'hA4, 1'b1);
    check("stl2_s01", {a_stage(0), a_stage(1)}, 16'hA3A2);
    check("stl2_s2_a", {a_sv[2], a_stage(2)}, {1'b0, 8'hF0});
    check("stl2_s3_a", {a_ov, a_od}, {1'b0, 8'hF0});
    check("stl2_s2_b", {b_sv[2], b_stage(2)}, {1'b1, 8'hA2});
    check("stl2_s3_b", {b_ov, b_od}, {1'b1, 8'hA2});
    check("stl2_cnt_a", {a_sc, a_bc}, {16'd2, 16'd2});
    check("stl2_cnt_b", {b_sc, b_bc}, {16'd2, 16'd0});
    stall = 4'b0000;
    for (int i = 2; i <= 6; i++) exp_q.push_back(8'hA0 + W'(i));
    for (int i = 0; i < 6; i++) begin
      drive(8'hA4 + W'(i), 1'b1);
      if (a_ov) begin
        if (exp_q.size() == 0) check("strm_extra", a_od, 8'hFF);
        else check("strm_order", a_od, exp_q.pop_front());
      end
    end
    check("strm_drained", exp_q.size(), 0);
    check("strm_bc_hold", a_bc, 16'd2);

    // stall and bubble together on stage 2
    do_reset();
    for (int i = 0; i < 3; i++) drive(8'hB0 + W'(i), 1'b1);
    stall = 4'b0100; bubble = 4'b0100;
    drive(8'hB3, 1'b1);
    check("cf_hold_s2", {a_sv[2], a_stage(2)}, {1'b1, 8'hB0});
    check("cf_s3_bub", {a_ov, a_od}, {1'b0, 8'hF0});
    check("cf_set", a_cf, 1'b1);
    stall = '0; bubble = '0; clear_cnt = 1'b1;
    drive(8'hB4, 1'b1);
    clear_cnt = 1'b0;
    drive(8'hB5, 1'b1);
    check("cf_sticky", a_cf, 1'b1);
    do_reset();
    check("cf_rst", a_cf, 1'b0);

    // counter saturation and clear
    stall = 4'b0001;
    for (int i = 0; i < 7; i++) drive(8'h00, 1'b0);
    check("sat_c7", c_sc, 3'd7);
    for (int i = 0; i < 3; i++) drive(8'h00, 1'b0);
    check("sat_c10", {c_sc, c_bc}, {3'd7, 3'd7});
    check("sat_a10", {a_sc, a_bc}, {16'd10, 16'd10});
    clear_cnt = 1'b1;
    drive(8'h00, 1'b0);
    check("clr_c", {c_sc, c_bc}, 6'd0);
    check("clr_a", {a_sc, a_bc}, 32'd0);
    clear_cnt = 1'b0;
    drive(8'h00, 1'b0);
    check("clr_resume", c_sc, 3'd1);

    // reset mid-stream while stalled
    stall = '0;
    do_reset();
    for (int i = 0; i < 4; i++) drive(8'hC0 + W'(i), 1'b1);
    stall = 4'b1111; bubble = 4'b1111;
    drive(8'hC4, 1'b1);
    check("mid_pre", {a_cf, a_sv, a_sc[3:0]}, {1'b1, 4'b1111, 4'd1});
    clear_cnt = 1'b1;
    do_reset();
    clear_cnt = 1'b0;
    check("mid_sd", a_sd, 32'hF0F0_F0F0);
    check("mid_sv", a_sv, 4'b0000);
    check("mid_cnt", {a_sc, a_bc, a_cf}, 33'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
